icache_controller: RTL and testbench
====================================

# icache_controller

Direct-mapped instruction cache controller between the fetch stage and the 128-bit block instruction memory. It serves 32-bit instruction reads from a small on-chip line store. On a miss it sequences one block read from instruction memory over that memory's read/busywait handshake, fills the line, and then replays the lookup. Its CPU-side port replaces the fetch stage's direct connection to instruction memory.

## Interface
Parameters:
- NUM_SETS, 8, number of lines; power of two, ≥2
- ADDR_W, 32, CPU byte-address width
- Derived, not overridable: OFFSET_W = 4 (16-byte line); INDEX_W = log2(NUM_SETS); TAG_W = ADDR_W − 4 − INDEX_W

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- read  in  1  CPU fetch request
- address  in  ADDR_W  CPU byte address (PC); bits [1:0] ignored
- readdata  out  32  fetched instruction
- busywait  out  1  CPU stall request
- mem_read  out  1  block-read request to instruction memory
- mem_address  out  ADDR_W−4  block address, equal to miss address[ADDR_W−1:4]
- mem_readdata  in  128  returned block; byte 0 in bits [7:0]
- mem_busywait  in  1  memory busy; asserted by memory while a read is pending

## Operation
- Address split: tag = address[ADDR_W−1:4+INDEX_W]; index = address[4+INDEX_W−1:4]; word = address[3:2].
- Per line: valid bit, tag, 128-bit data. readdata = line data[32*word +: 32].
- hit = read & valid[index] & (tag_store[index] == tag). Evaluated combinationally in IDLE.
- FSM states:
  - IDLE: if read & !hit, latch block address and index, go to MEM_READ; otherwise stay.
  - MEM_READ: mem_read = 1, mem_address = latched block address. Move to UPDATE on the first posedge where mem_busywait == 0, excluding the entry cycle.
  - UPDATE: write mem_readdata, latched tag and valid = 1 into the latched index. mem_read = 0. Go to IDLE.
- busywait:
  - IDLE: busywait = read & !hit (combinational).
  - MEM_READ and UPDATE: busywait = 1.
- The CPU holds address and read while busywait is high. The fill uses the latched address regardless.
- read low in IDLE: busywait = 0, no state change. readdata is don't-care.
- No write path. No invalidate input; reset is the only flush.

## Timing
- Reset (synchronous): all valid bits = 0, state = IDLE, mem_read = 0, latched address = 0. Tag and data arrays are not cleared.
- During reset and in the cycle after it: busywait = 0, mem_read = 0.
- Hit latency: zero cycles. readdata is valid in the same cycle read and address are presented.
- Miss latency, counted in cycles from the miss cycle:
  - 1 cycle to enter MEM_READ.
  - N memory cycles, until mem_busywait falls.
  - 1 cycle in UPDATE.
  - The hit is served in the following IDLE cycle.
- mem_read is high for exactly the MEM_READ cycles. It drops when the FSM leaves MEM_READ.
- Reset asserted in MEM_READ or UPDATE: the fill is abandoned, no line is written, mem_read = 0 next cycle.
- Back-to-back misses to different lines: each miss goes through the full IDLE→MEM_READ→UPDATE cycle. There is no overlap and no prefetch.
- A conflict miss overwrites the line unconditionally. There is no write-back.
- Index wrap: with NUM_SETS = 8, byte address 0x80 maps to set 0 with tag 1.

## Structure
- Package icache_pkg holds:
  - the state enum {IDLE, MEM_READ, UPDATE}
  - OFFSET_W and the field-extraction functions
  - the 32-bit word-select helper
- Sub-module icache_line_store: valid/tag/data arrays, synchronous write port, combinational read port, synchronous valid clear on reset.
- The FSM and hit logic stay in icache_controller.

## Test plan
- Cold miss: after reset, read=1, address=0x00.
  - Required: busywait=1, mem_read=1 with mem_address=0 until the memory returns a block whose word 0 is 0x00500093.
  - Then one UPDATE cycle, then readdata=0x00500093 with busywait=0.
- Same-line hits: address 0x04, 0x08, 0x0C after the fill.
  - Required: busywait=0 every cycle, readdata = words 1–3 of the block (word 1 = 0x00506113), and mem_read stays 0.
- Conflict miss: with set 0 filled at 0x00, read 0x80.
  - Required: a miss with mem_address=0x8. The line is replaced.
  - A re-read of 0x00 must then miss again.
- Reset mid-fill: assert reset two cycles into MEM_READ.
  - Required: mem_read=0 and busywait=0 on the next cycle, and a later read of the same address misses.
- Address change during a stall: change address after the miss cycle.
  - Required: the fill still uses the original latched block address.
- Idle: read=0 for 10 cycles.
  - Required: busywait=0 and mem_read=0 throughout.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Holds the controller state enum, the line geometry and the address
// field extraction / word-select helpers used by the controller.
package icache_pkg;

    localparam int unsigned OFFSET_W = 4;    // 16-byte line
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned LINE_W   = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_e;

    // Block address: byte address with the line offset stripped.
    function automatic logic [63:0] addr_block(input logic [63:0] addr);
        return addr >> OFFSET_W;
    endfunction

    // Set index: low index_w bits of the block address.
    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int unsigned index_w);
        return addr_block(addr) & ((64'd1 << index_w) - 64'd1);
    endfunction

    // Tag: everything above offset and index.
    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int unsigned index_w);
        return addr >> (OFFSET_W + index_w);
    endfunction

    // Word within the line (address bits [3:2]).
    function automatic logic [1:0] addr_word(input logic [63:0] addr);
        return 2'(addr >> 2);
    endfunction

    // Select one 32-bit word from a 128-bit line; byte 0 sits in bits [7:0].
    function automatic logic [WORD_W-1:0] word_select(input logic [LINE_W-1:0] line,
                                                      input logic [1:0]        word);
        return line[WORD_W*word +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Line storage for the instruction cache: valid bits, tags and 128-bit
// line data per set.
// Ports:
//   clock, reset          - clock, synchronous active-high reset (clears valid only)
//   rd_index              - combinational lookup index
//   rd_valid/tag/data     - contents of the looked-up set
//   wr_en/index/tag/data  - synchronous line fill; sets valid for that set
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned INDEX_W  = 3,
    parameter int unsigned TAG_W    = 25
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_data
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] valid_d;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [LINE_W-1:0]   data_q [NUM_SETS];

    // Valid bit set on fill.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // Reset only flushes valid bits; tag/data arrays keep stale contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller between fetch and the
// 128-bit block instruction memory. Hits return in the same cycle; a miss
// latches the block address, reads one block from memory, fills the line
// and replays the lookup.
// Ports:
//   clock, reset              - clock, synchronous active-high reset
//   read, address             - CPU fetch request and byte address (PC)
//   readdata, busywait        - fetched instruction, CPU stall
//   mem_read, mem_address     - block read request and block address
//   mem_readdata, mem_busywait- returned block, memory busy
module icache_controller
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  read,
    input  logic [ADDR_W-1:0]     address,
    output logic [WORD_W-1:0]     readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic [ADDR_W-5:0]     mem_address,
    input  logic [LINE_W-1:0]     mem_readdata,
    input  logic                  mem_busywait
);

    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned BLK_W   = ADDR_W - OFFSET_W;
    localparam int unsigned TAG_W   = ADDR_W - OFFSET_W - INDEX_W;

    logic [TAG_W-1:0]   cpu_tag;
    logic [INDEX_W-1:0] cpu_index;
    logic [1:0]         cpu_word;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [LINE_W-1:0]  line_data;
    logic               hit;
    logic               fill_en;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   blk_addr_q, blk_addr_d;
    logic               mem_read_q, mem_read_d;

    // CPU address decode.
    assign cpu_tag   = TAG_W'(addr_tag(64'(address), INDEX_W));
    assign cpu_index = INDEX_W'(addr_index(64'(address), INDEX_W));
    assign cpu_word  = addr_word(64'(address));

    // Fill writes the latched block; suppressed if reset lands in UPDATE.
    assign fill_en = (state_q == UPDATE) && !reset;

    icache_line_store #(
        .NUM_SETS (NUM_SETS),
        .INDEX_W  (INDEX_W),
        .TAG_W    (TAG_W)
    ) u_line_store (
        .clock    (clock),
        .reset    (reset),
        .rd_index (cpu_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill_en),
        .wr_index (blk_addr_q[INDEX_W-1:0]),
        .wr_tag   (blk_addr_q[BLK_W-1:INDEX_W]),
        .wr_data  (mem_readdata)
    );

    assign hit      = read && line_valid && (line_tag == cpu_tag);
    assign readdata = word_select(line_data, cpu_word);

    // Next-state: one block read per miss, no overlap.
    always_comb begin
        state_d    = state_q;
        blk_addr_d = blk_addr_q;
        case (state_q)
            IDLE: begin
                if (read && !hit) begin
                    blk_addr_d = BLK_W'(addr_block(64'(address)));
                    state_d    = MEM_READ;
                end
            end
            MEM_READ: begin
                if (!mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_read_d = (state_d == MEM_READ);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            blk_addr_q <= '0;
            mem_read_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_addr_q <= blk_addr_d;
            mem_read_q <= mem_read_d;
        end
    end

    // Stall: lookup result in IDLE, always while a fill is in flight;
    // forced low while reset is held so an abandoned fill releases the CPU.
    always_comb begin
        busywait = 1'b0;
        if (!reset) begin
            if (state_q == IDLE) begin
                busywait = read && !hit;
            end else begin
                busywait = 1'b1;
            end
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_address = blk_addr_q;

endmodule

// File: tb/tb_icache_controller.sv
module tb_icache_controller;

    localparam int unsigned NUM_SETS = 8;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INDEX_W  = 3;
    localparam int unsigned BLK_W    = ADDR_W - 4;
    localparam int unsigned TAG_W    = BLK_W - INDEX_W;

    logic               clock;
    logic               reset;
    logic               read;
    logic [ADDR_W-1:0]  address;
    logic [31:0]        readdata;
    logic               busywait;
    logic               mem_read;
    logic [BLK_W-1:0]   mem_address;
    logic [127:0]       mem_readdata;
    logic               mem_busywait;

    int checks = 0;
    int errors = 0;

    icache_controller #(.NUM_SETS(NUM_SETS), .ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .read         (read),
        .address      (address),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory contents: block 0 holds a known program prefix.
    function automatic logic [127:0] mem_block(input logic [BLK_W-1:0] blk);
        logic [127:0] b;
        if (blk == '0) begin
            b = {32'h00000013, 32'h00a00193, 32'h00506113, 32'h00500093};
        end else begin
            for (int i = 0; i < 4; i++) begin
                b[32*i +: 32] = {blk[15:0], 14'h2a5, 2'(i)} ^ 32'h13579bdf;
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] b, input logic [1:0] w);
        return 32'(b >> (32 * int'(w)));
    endfunction

    // Memory model: busy from the moment read rises; data returned after
    // mem_lat counted cycles and held until read drops.
    int unsigned mem_lat = 1;
    int unsigned mem_cnt = 1;
    logic        mem_ready = 1'b0;
    assign mem_busywait = mem_read && !mem_ready;

    always @(posedge clock) begin
        if (!mem_read) begin
            mem_ready <= 1'b0;
            mem_cnt   <= mem_lat;
        end else if (mem_cnt <= 1) begin
            mem_ready    <= 1'b1;
            mem_readdata <= mem_block(mem_address);
        end else begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    // Reference cache state.
    bit               model_valid [NUM_SETS];
    logic [TAG_W-1:0] model_tag   [NUM_SETS];
    logic [127:0]     model_data  [NUM_SETS];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < NUM_SETS; i++) model_valid[i] = 1'b0;
    endtask

    // One fetch: same-cycle hit, or full miss sequence with fill and replay.
    task automatic do_fetch(input logic [31:0] addr, input bit change);
        logic [BLK_W-1:0]   blk;
        int unsigned        set;
        logic [TAG_W-1:0]   tag;
        bit                 exp_hit;
        int unsigned        lat;
        blk = addr[31:4];
        set = int'(blk[INDEX_W-1:0]);
        tag = blk[BLK_W-1:INDEX_W];
        lat = $urandom_range(1, 4);
        @(negedge clock);
        read    = 1'b1;
        address = addr;
        mem_lat = lat;
        #1;
        exp_hit = model_valid[set] && (model_tag[set] == tag);
        check("lookup_busywait", 128'(busywait), 128'(!exp_hit));
        check("lookup_mem_read", 128'(mem_read), 128'(0));
        if (exp_hit) begin
            check("hit_readdata", 128'(readdata), 128'(word_of(model_data[set], addr[3:2])));
            return;
        end
        for (int k = 0; k <= int'(lat); k++) begin
            @(negedge clock);
            if (change && k == 0) address = addr ^ 32'h0000_0150;
            #1;
            check("memrd_req", 128'(mem_read), 128'(1));
            check("memrd_busy", 128'(busywait), 128'(1));
            check("memrd_addr", 128'(mem_address), 128'(blk));
        end
        @(negedge clock);
        address = addr;
        #1;
        check("update_mem_read", 128'(mem_read), 128'(0));
        check("update_busy", 128'(busywait), 128'(1));
        model_valid[set] = 1'b1;
        model_tag[set]   = tag;
        model_data[set]  = mem_block(blk);
        @(negedge clock);
        #1;
        check("replay_busy", 128'(busywait), 128'(0));
        check("replay_readdata", 128'(readdata), 128'(word_of(model_data[set], addr[3:2])));
        check("replay_mem_read", 128'(mem_read), 128'(0));
    endtask

    initial begin
        reset   = 1'b1;
        read    = 1'b1;
        address = '0;
        model_flush();

        // Reset held with a pending request: no stall, no memory request.
        repeat (2) begin
            @(negedge clock);
            #1;
            check("reset_busywait", 128'(busywait), 128'(0));
            check("reset_mem_read", 128'(mem_read), 128'(0));
        end
        @(negedge clock);
        reset = 1'b0;
        read  = 1'b0;
        #1;
        check("post_reset_busywait", 128'(busywait), 128'(0));
        check("post_reset_mem_read", 128'(mem_read), 128'(0));

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            check("idle_busywait", 128'(busywait), 128'(0));
            check("idle_mem_read", 128'(mem_read), 128'(0));
        end

        // Cold miss, then same-line hits.
        do_fetch(32'h0000_0000, 1'b0);
        check("cold_word0", 128'(readdata), 128'(32'h00500093));
        do_fetch(32'h0000_0004, 1'b0);
        check("hit_word1", 128'(readdata), 128'(32'h00506113));
        do_fetch(32'h0000_0008, 1'b0);
        do_fetch(32'h0000_000C, 1'b0);

        // Conflict miss on set 0, then the original line misses again.
        do_fetch(32'h0000_0080, 1'b0);
        do_fetch(32'h0000_0000, 1'b0);

        // Address moves during the stall; fill uses the latched block.
        do_fetch(32'h0000_0124, 1'b1);

        // Reset two cycles into MEM_READ abandons the fill.
        @(negedge clock);
        read    = 1'b1;
        address = 32'h0000_0200;
        mem_lat = 4;
        #1;
        check("rst_fill_miss", 128'(busywait), 128'(1));
        @(negedge clock);
        #1;
        check("rst_fill_memrd", 128'(mem_read), 128'(1));
        @(negedge clock);
        reset = 1'b1;
        read  = 1'b0;
        #1;
        check("rst_fill_busy_in_reset", 128'(busywait), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_fill_mem_read", 128'(mem_read), 128'(0));
        check("rst_fill_busywait", 128'(busywait), 128'(0));
        model_flush();
        do_fetch(32'h0000_0200, 1'b0);
        do_fetch(32'h0000_0004, 1'b0);

        // Randomized fetches over a small footprint to force conflicts.
        for (int i = 0; i < 60; i++) begin
            do_fetch($urandom_range(0, 32'h3ff), ($urandom_range(0, 3) == 0));
        end

        @(negedge clock);
        read = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
